pp_accum_pipe: RTL and testbench

Pipelined, parametrised partial-product accumulator for the wide-radix multiplier datapath. Accepts a ROWS×COLS grid of PP_W-bit partial products per beat and shifts each into its weight position. The shifted products are summed over two registered stages into a 2·RADIX-bit result. A valid/ready handshake carries full backpressure, and an optional compile-time mode accumulates several beats into one result.

---
 rtl/pp_accum_pipe.sv | 158 +++++++++++++++
 tb/tb_pp_accum_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accum_pipe.sv
// Two-stage partial-product accumulator: per-row shifted sums in S1, row total in S2.
// Optional multi-beat group accumulation enabled by defining PP_ACCUM_MULTI_EN.
`timescale 1ns/1ps
module pp_accum_pipe #(
    parameter int unsigned PP_W     = 45,
    parameter int unsigned RADIX    = 54,
    parameter int unsigned COLS     = 3,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned COL_STEP = 18,
    parameter int unsigned ROW_OFF  = 27
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS*COLS*PP_W-1:0]    in_pp,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*RADIX-1:0]           out_res,
    output logic [7:0]                   out_beats
);

    localparam int unsigned OUT_W = 2 * RADIX;

    logic [OUT_W-1:0] row_sum [ROWS];
    logic [OUT_W-1:0] s1_row_d [ROWS];
    logic [OUT_W-1:0] s1_row_q [ROWS];
    logic [OUT_W-1:0] s1_total;
    logic             s1_valid_d, s1_valid_q;
    logic             s1_last_d, s1_last_q;
    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] out_res_d, out_res_q;
    logic [7:0]       out_beats_d, out_beats_q;
    logic             s2_load, s1_load, accept, xfer;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign accept   = in_valid && s1_load;
    assign xfer     = s1_valid_q && s2_load;
    assign in_ready = s1_load;

    // Zero-extend each product to OUT_W, shift into its weight, sum per row.
    always_comb begin
        for (int r = 0; r < int'(ROWS); r++) begin
            row_sum[r] = '0;
            for (int c = 0; c < int'(COLS); c++) begin
                row_sum[r] = row_sum[r] +
                    (OUT_W'(in_pp[(r*int'(COLS)+c)*int'(PP_W) +: PP_W]) << (r*int'(ROW_OFF) + c*int'(COL_STEP)));
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        for (int r = 0; r < int'(ROWS); r++) begin
            s1_row_d[r] = s1_row_q[r];
        end
        if (s1_load) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_last_d = in_last;
            for (int r = 0; r < int'(ROWS); r++) begin
                s1_row_d[r] = row_sum[r];
            end
        end
    end

    always_comb begin
        s1_total = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            s1_total = s1_total + s1_row_q[r];
        end
    end

`ifdef PP_ACCUM_MULTI_EN
    logic [OUT_W-1:0] acc_d, acc_q, acc_next;
    logic [7:0]       cnt_d, cnt_q, cnt_next;
    logic             first_d, first_q;

    // Group accumulation; a result is published only on the group's last beat.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_res_d   = out_res_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q && !out_ready;
        acc_next    = first_q ? s1_total : acc_q + s1_total;
        cnt_next    = first_q ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        if (xfer) begin
            acc_d   = acc_next;
            cnt_d   = cnt_next;
            first_d = s1_last_q;
            if (s1_last_q) begin
                out_res_d   = acc_next;
                out_beats_d = cnt_next;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end
`else
    logic unused_last;
    assign unused_last = s1_last_q;

    always_comb begin
        out_res_d   = out_res_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q && !out_ready;
        if (xfer) begin
            out_res_d   = s1_total;
            out_beats_d = 8'd1;
            out_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_beats_q <= '0;
            for (int r = 0; r < int'(ROWS); r++) begin
                s1_row_q[r] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_beats_q <= out_beats_d;
            for (int r = 0; r < int'(ROWS); r++) begin
                s1_row_q[r] <= s1_row_d[r];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pp_accum_pipe.sv
// Scoreboard bench for pp_accum_pipe: full-precision reference sum, queue of expected results.
`timescale 1ns/1ps
module tb_pp_accum_pipe;

    localparam int unsigned PP_W  = 45;
    localparam int unsigned NPP   = 6;
    localparam int unsigned IN_W  = NPP * PP_W;
    localparam int unsigned OUT_W = 108;

    typedef struct packed {
        logic [OUT_W-1:0] res;
        logic [7:0]       beats;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_pp = '0;
    logic             in_last = 1'b1;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_res;
    logic [7:0]       out_beats;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int cyc    = 0;
    exp_t sb[$];

    logic [OUT_W-1:0] m_acc = '0;
    logic [7:0]       m_cnt = '0;
    logic             m_first = 1'b1;

    logic             prev_hold = 1'b0;
    logic [OUT_W-1:0] prev_res = '0;
    logic [7:0]       prev_beats = '0;
    logic             rand_done = 1'b0;

    pp_accum_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pp(in_pp), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_beats(out_beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OUT_W-1:0] model_sum(input logic [IN_W-1:0] pp);
        logic [255:0] t;
        int r, c;
        t = '0;
        for (int k = 0; k < int'(NPP); k++) begin
            r = k / 3;
            c = k % 3;
            t = t + (256'(pp[k*int'(PP_W) +: PP_W]) << (r*27 + c*18));
        end
        return t[OUT_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] rand_pp();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[IN_W-1:0];
    endfunction

    // Reference model of one accepted beat.
    task automatic model_accept(input logic [IN_W-1:0] pp, input logic last);
        exp_t e;
        logic [OUT_W-1:0] s;
        s = model_sum(pp);
`ifdef PP_ACCUM_MULTI_EN
        m_acc = m_first ? s : m_acc + s;
        m_cnt = m_first ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
        m_first = last;
        if (last) begin
            e.res = m_acc;
            e.beats = m_cnt;
            sb.push_back(e);
        end
`else
        e.res = s;
        e.beats = 8'd1;
        sb.push_back(e);
`endif
    endtask

    task automatic send_beat(input logic [IN_W-1:0] pp, input logic last);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_pp = pp;
        in_last = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(pp, last);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready stuck at %0b, need 1", in_ready);
        end
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        for (i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d, need 0", sb.size());
        end
    endtask

    // Output monitor: scoreboard compare on handshake, stability during stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== prev_res || out_beats !== prev_beats) begin
                    errors++;
                    $display("FAIL stall_stable res %h beats %0d v %0b, need %h %0d 1",
                             out_res, out_beats, out_valid, prev_res, prev_beats);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out res %h, need no output", out_res);
                end else begin
                    e = sb.pop_front();
                    if (out_res !== e.res || out_beats !== e.beats) begin
                        errors++;
                        $display("FAIL result res %h beats %0d, need %h %0d",
                                 out_res, out_beats, e.res, e.beats);
                    end
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_res   = out_res;
            prev_beats = out_beats;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_res !== '0 || in_ready !== 1'b1 || out_beats !== 8'd0) begin
            errors++;
            $display("FAIL reset_state v %0b res %h rdy %0b beats %0d, need 0 0 1 0",
                     out_valid, out_res, in_ready, out_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [IN_W-1:0] pp;
        logic [OUT_W-1:0] want;
        want = (108'd1 << 0) | (108'd1 << 18) | (108'd1 << 36) |
               (108'd1 << 27) | (108'd1 << 45) | (108'd1 << 63);
        for (int k = 0; k < int'(NPP); k++) pp[k*int'(PP_W) +: PP_W] = 45'd1;
        out_ready = 1'b1;
        send_beat(pp, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid %0b, need 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== want || out_beats !== 8'd1) begin
            errors++;
            $display("FAIL single_beat v %0b res %h beats %0d, need 1 %h 1",
                     out_valid, out_res, out_beats, want);
        end
        drain();
    endtask

    task automatic test_all_ones();
        logic [IN_W-1:0] pp;
        pp = '1;
        send_beat(pp, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        int c0, n0;
        out_ready = 1'b1;
        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 1000; i++) send_beat(rand_pp(), 1'b1);
        checks++;
        if (cyc - c0 != 1000) begin
            errors++;
            $display("FAIL throughput cycles %0d, need 1000", cyc - c0);
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (n_out - n0 != 1000) begin
            errors++;
            $display("FAIL b2b_count results %0d, need 1000", n_out - n0);
        end
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0] p3;
        int n0;
        n0 = n_out;
        out_ready = 1'b0;
        send_beat(rand_pp(), 1'b1);
        send_beat(rand_pp(), 1'b1);
        p3 = rand_pp();
        in_valid = 1'b1;
        in_pp = p3;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall rdy %0b v %0b, need 0 1", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold rdy %0b, need 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(p3, 1'b1);
        in_valid = 1'b0;
        drain();
        checks++;
        if (n_out - n0 != 3) begin
            errors++;
            $display("FAIL bp_count results %0d, need 3", n_out - n0);
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = n_out;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(1, 0) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_beat(rand_pp(), 1'b1);
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(1, 0) == 1);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        checks++;
        if (n_out - n0 != 2000) begin
            errors++;
            $display("FAIL random_count results %0d, need 2000", n_out - n0);
        end
    endtask

    task automatic test_mid_reset();
        int n0;
        out_ready = 1'b0;
        send_beat(rand_pp(), 1'b1);
        send_beat(rand_pp(), 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_first = 1'b1;
        m_acc = '0;
        m_cnt = '0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset v %0b rdy %0b, need 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n0 = n_out;
        out_ready = 1'b1;
        send_beat(rand_pp(), 1'b1);
        in_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_out - n0 != 1) begin
            errors++;
            $display("FAIL post_reset_count results %0d, need 1", n_out - n0);
        end
    endtask

`ifdef PP_ACCUM_MULTI_EN
    task automatic test_multi();
        logic [IN_W-1:0] p5, p7;
        int n0;
        p5 = '0;
        p5[PP_W-1:0] = 45'd5;
        p7 = '0;
        p7[PP_W-1:0] = 45'd7;
        n0 = n_out;
        out_ready = 1'b1;
        send_beat(p5, 1'b0);
        send_beat(p5, 1'b0);
        send_beat(p5, 1'b1);
        send_beat(p7, 1'b1);
        in_valid = 1'b0;
        checks++;
        if (sb.size() < 2 || sb[0].res !== 108'd15 || sb[0].beats !== 8'd3 ||
            sb[1].res !== 108'd7 || sb[1].beats !== 8'd1) begin
            errors++;
            $display("FAIL multi_model queued %0d, need 15/3 then 7/1", sb.size());
        end
        drain();
        checks++;
        if (n_out - n0 != 2) begin
            errors++;
            $display("FAIL multi_count results %0d, need 2", n_out - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
`ifdef PP_ACCUM_MULTI_EN
        test_multi();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
